// File: rtl/mapa_pkg.sv
// Shared constants, state encodings and helpers for the mapa_blocos tile-map store.
package mapa_pkg;

    localparam int SCREEN_WIDTH_DEF  = 640;
    localparam int SCREEN_HEIGHT_DEF = 480;
    localparam int BLOCK_BITS_DEF    = 4;

    localparam int MAP_W = SCREEN_WIDTH_DEF >> BLOCK_BITS_DEF;
    localparam int MAP_H = SCREEN_HEIGHT_DEF >> BLOCK_BITS_DEF;
    localparam int N     = MAP_W * MAP_H;
    localparam int IDX_W = $clog2(N);

    localparam logic [5:0] COR_FUNDO = 6'b000000;
    localparam logic [5:0] COR_BORDA = 6'b111111;

    typedef enum logic {
        IDLE  = 1'b0,
        LIMPA = 1'b1
    } estado_t;

    // Which source drives mapa_cor after a read.
    typedef enum logic [1:0] {
        SEL_FUNDO = 2'd0,
        SEL_BORDA = 2'd1,
        SEL_RAM   = 2'd2
    } sel_t;

    function automatic logic na_borda(input logic [9:0] x, input logic [9:0] y,
                                      input logic [9:0] mw, input logic [9:0] mh);
        return (x == 10'd0) || (x == mw - 10'd1) || (y == 10'd0) || (y == mh - 10'd1);
    endfunction

endpackage

// File: rtl/mapa_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write), no reset.
module mapa_ram #(
    parameter int DEPTH = 1200,
    parameter int AW    = 11,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; a same-edge write is not seen, so the old value is returned.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mapa_blocos.sv
// Tile-map store: renderer read port, valid/ready write port and a clear sweep FSM.
// Optional fixed border cells when MAPA_BORDA_EN is defined.
module mapa_blocos
    import mapa_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BLOCK_BITS    = 4,
    parameter int BLOCK_SIZE    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mapa_read,
    input  logic [9:0] mapa_x,
    input  logic [9:0] mapa_y,
    output logic [5:0] mapa_cor,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [9:0] wr_x,
    input  logic [9:0] wr_y,
    input  logic [5:0] wr_cor,
    input  logic       limpar,
    output logic       ocupado
);

    localparam int MW = SCREEN_WIDTH >> BLOCK_BITS;
    localparam int MH = SCREEN_HEIGHT >> BLOCK_BITS;
    localparam int NC = MW * MH;
    localparam int IW = $clog2(NC);

    localparam logic [9:0]    MW_C   = 10'(MW);
    localparam logic [9:0]    MH_C   = 10'(MH);
    localparam logic [19:0]   MW_L   = 20'(MW);
    localparam logic [IW-1:0] ULTIMO = IW'(NC - 1);

    if (BLOCK_SIZE != (1 << BLOCK_BITS)) begin : g_block_size_check
        $error("BLOCK_SIZE must equal 2**BLOCK_BITS");
    end

    estado_t       estado_q, estado_d;
    logic [IW-1:0] idx_q, idx_d;
    sel_t          sel_q, sel_d;

    logic          rd_in_s, wr_in_s;
    logic          rd_borda_s, wr_borda_s;
    logic          wr_ready_s;
    logic          ram_we_s, ram_re_s;
    logic [IW-1:0] ram_waddr_s, ram_raddr_s;
    logic [5:0]    ram_wdata_s, ram_rdata_s;
    logic [IW-1:0] wr_idx_s;

    // Bounds use the full 10-bit coordinate so out-of-range values cannot alias.
    assign rd_in_s = (mapa_x < MW_C) && (mapa_y < MH_C);
    assign wr_in_s = (wr_x < MW_C) && (wr_y < MH_C);

`ifdef MAPA_BORDA_EN
    assign rd_borda_s = na_borda(mapa_x, mapa_y, MW_C, MH_C);
    assign wr_borda_s = na_borda(wr_x, wr_y, MW_C, MH_C);
`else
    assign rd_borda_s = 1'b0;
    assign wr_borda_s = 1'b0;
`endif

    assign ram_raddr_s = IW'(20'(mapa_y) * MW_L + 20'(mapa_x));
    assign wr_idx_s    = IW'(20'(wr_y) * MW_L + 20'(wr_x));
    assign ram_re_s    = mapa_read && rd_in_s;

    assign wr_ready_s = (estado_q == IDLE) && !limpar;
    assign wr_ready   = wr_ready_s;
    assign ocupado    = (estado_q == LIMPA);

    // Clear sweep next-state and index.
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        case (estado_q)
            IDLE: begin
                if (limpar) begin
                    estado_d = LIMPA;
                    idx_d    = {IW{1'b0}};
                end else begin
                    estado_d = IDLE;
                end
            end
            LIMPA: begin
                if (idx_q == ULTIMO) begin
                    estado_d = IDLE;
                    idx_d    = {IW{1'b0}};
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                estado_d = LIMPA;
                idx_d    = {IW{1'b0}};
            end
        endcase
    end

    // RAM write arbitration: the sweep owns the write port while it runs.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_idx_s;
        ram_wdata_s = wr_cor;
        if (estado_q == LIMPA) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = idx_q;
            ram_wdata_s = COR_FUNDO;
        end else begin
            ram_we_s = wr_valid && wr_ready_s && wr_in_s && !wr_borda_s;
        end
    end

    // Output source flag, captured alongside the RAM read.
    always_comb begin
        sel_d = sel_q;
        if (mapa_read) begin
            if (!rd_in_s) begin
                sel_d = SEL_FUNDO;
            end else if (rd_borda_s) begin
                sel_d = SEL_BORDA;
            end else begin
                sel_d = SEL_RAM;
            end
        end else begin
            sel_d = sel_q;
        end
    end

    // State, index and output-select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= LIMPA;
            idx_q    <= {IW{1'b0}};
            sel_q    <= SEL_FUNDO;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
        end
    end

    // Output mux over registered sources only.
    always_comb begin
        case (sel_q)
            SEL_BORDA: mapa_cor = COR_BORDA;
            SEL_RAM:   mapa_cor = ram_rdata_s;
            default:   mapa_cor = COR_FUNDO;
        endcase
    end

    mapa_ram #(
        .DEPTH (NC),
        .AW    (IW),
        .DW    (6)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

endmodule
